load_use_scoreboard: RTL

- Parametrised successor to the decode-stage load-use hazard detector. Replaces the single-stage EX_MemRead/EX_WriteRegister compare with a per-register countdown scoreboard, so load latency is configurable (LOAD_LAT ≥ 1) and multiple loads may be in flight.
- Sits in ID. It drives the PC/IF_ID write enable and the ID_EX control-bubble signal, tracks pending load destinations, and counts stall cycles for performance monitoring.

---
 rtl/load_use_scoreboard.sv | 83 ++++++++
 1 files changed

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use hazard detector built on a per-register countdown scoreboard.
// Handles configurable load latency, several loads in flight, flushes and stall-cycle counting.
module load_use_scoreboard #(
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int SCW      = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rs,
   input  logic [AW-1:0]   id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic            id_wr_en,
   input  logic [AW-1:0]   id_wr_reg,
   input  logic            id_is_load,
   input  logic            flush_id,
   input  logic            flush_all,
   output logic            stall,
   output logic            pc_if_id_write,
   output logic            bubble,
   output logic [NREG-1:0] pending,
   output logic [SCW-1:0]  stall_cycles
);

   localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

   // Register 0 is hard-wired, so its counter does not exist at all.
   logic [CW-1:0] cnt      [1:NREG-1];
   logic [CW-1:0] cnt_next [1:NREG-1];
   logic          rs_busy;
   logic          rt_busy;
   logic          hazard;
   logic          issue;

   always_comb begin
      rs_busy = 1'b0;
      rt_busy = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         if (id_rs == AW'(r) && cnt[r] != '0) rs_busy = 1'b1;
         if (id_rt == AW'(r) && cnt[r] != '0) rt_busy = 1'b1;
      end
   end

   assign hazard         = id_valid & ((id_use_rs & rs_busy) | (id_use_rt & rt_busy));
   assign stall          = hazard & ~flush_id & ~flush_all;
   assign pc_if_id_write = ~stall;
   assign bubble         = stall | flush_id | flush_all;
   assign issue          = id_valid & ~stall & ~flush_id & ~flush_all;

   // A newer load reloads the countdown (WAW); a newer ALU write clears it,
   // since forwarding prefers the younger producer.
   always_comb begin
      for (int r = 1; r < NREG; r++) begin
         cnt_next[r] = cnt[r];
         if (flush_all) begin
            cnt_next[r] = '0;
         end else if (issue && id_wr_en && id_wr_reg == AW'(r)) begin
            cnt_next[r] = id_is_load ? CW'(LOAD_LAT) : '0;
         end else if (cnt[r] != '0) begin
            cnt_next[r] = cnt[r] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 1; r < NREG; r++) cnt[r] <= '0;
         pending      <= '0;
         stall_cycles <= '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            cnt[r]     <= cnt_next[r];
            pending[r] <= (cnt_next[r] != '0);
         end
         pending[0] <= 1'b0;
         if (stall && stall_cycles != {SCW{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule
